// File: rtl/lsu.sv
// Load/store unit: issues one word-aligned bus access per request over a req/gnt + rvalid
// handshake and returns extended load data; bad or timed-out accesses complete with err_o.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] load_data_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_addr;
    logic          r_we;
    logic [2:0]    r_funct3;
    logic [1:0]    r_lane;
    logic [3:0]    r_wstrb;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [31:0]   r_load_data;

    logic          w_bad;
    logic          w_expire;
    logic [3:0]    w_strb;
    logic [31:0]   w_wdata;
    logic [31:0]   w_shift;
    logic [31:0]   w_load;

    assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == LIMIT);

    // funct3 4/5 (unsigned loads) do not exist for stores
    always_comb begin
        w_bad = 1'b1;
        case (req_funct3_i)
            3'd0:    w_bad = 1'b0;
            3'd1:    w_bad = req_addr_i[0];
            3'd2:    w_bad = |req_addr_i[1:0];
            3'd4:    w_bad = req_we_i;
            3'd5:    w_bad = req_we_i | req_addr_i[0];
            default: w_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_strb  = '0;
        w_wdata = '0;
        if (req_we_i) begin
            case (req_funct3_i[1:0])
                2'd0: begin
                    w_strb  = 4'b0001 << req_addr_i[1:0];
                    w_wdata = {4{req_wdata_i[7:0]}};
                end
                2'd1: begin
                    w_strb  = 4'b0011 << req_addr_i[1:0];
                    w_wdata = {2{req_wdata_i[15:0]}};
                end
                default: begin
                    w_strb  = 4'b1111;
                    w_wdata = req_wdata_i;
                end
            endcase
        end
    end

    always_comb begin
        w_shift = bus_rdata_i >> {r_lane, 3'b000};
        case (r_funct3)
            3'd0:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'd1:    w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'd4:    w_load = {24'b0, w_shift[7:0]};
            3'd5:    w_load = {16'b0, w_shift[15:0]};
            default: w_load = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // a response in the expiry cycle completes normally; in REQ the timeout wins over gnt
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid_i) w_next = w_bad ? S_DONE : S_REQ;
            S_REQ:  if (w_expire) w_next = S_DONE;
                    else if (bus_gnt_i) w_next = S_WAIT;
            S_WAIT: if (bus_rvalid_i || w_expire) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (r_state != S_IDLE);
        done_o    = (r_state == S_DONE);
        err_o     = (r_state == S_DONE) && r_err;
        bus_req_o = (r_state == S_REQ);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_lane      <= '0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_load_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid_i) begin
                    r_err <= w_bad;
                    if (!w_bad) begin
                        r_addr   <= {req_addr_i[31:2], 2'b00};
                        r_we     <= req_we_i;
                        r_funct3 <= req_funct3_i;
                        r_lane   <= req_addr_i[1:0];
                        r_wstrb  <= w_strb;
                        r_wdata  <= w_wdata;
                        r_cnt    <= '0;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_expire) r_err <= 1'b1;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (bus_rvalid_i) begin
                        r_err <= 1'b0;
                        if (!r_we) r_load_data <= w_load;
                    end else if (w_expire) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign load_data_o = r_load_data;
    assign bus_addr_o  = r_addr;
    assign bus_we_o    = r_we;
    assign bus_wstrb_o = r_wstrb;
    assign bus_wdata_o = r_wdata;
endmodule
